// File: rtl/stdp_pkg.sv
// -----------------------------------------------------------------------------
// stdp_pkg
// Shared defaults and the saturating clamp helper for the LIF/STDP neuron pair.
// The constants set the default parameters of lif_neuron and lif_stdp_pair.
// clamp_u limits a signed value to the range [0, hi]. Both the membrane
// saturation and the weight update use it.
// -----------------------------------------------------------------------------
package stdp_pkg;

  localparam int W_DEF          = 8;
  localparam int WW_DEF         = 8;
  localparam int TW_DEF         = 4;
  localparam int LEAK_SHIFT_DEF = 3;
  localparam int THRESH_DEF     = 200;
  localparam int W_INIT_DEF     = 64;
  localparam int W_MAX_DEF      = 255;
  localparam int A_PLUS_DEF     = 16;
  localparam int A_MINUS_DEF    = 16;

  // Clamp a signed value into [0, hi]; 34 bits hold any 32-bit sum/difference.
  function automatic logic [31:0] clamp_u(input logic signed [33:0] val,
                                          input logic [31:0] hi);
    logic signed [33:0] hi_s;
    hi_s = $signed({2'b00, hi});
    if (val < 34'sd0) begin
      clamp_u = 32'd0;
    end else if (val > hi_s) begin
      clamp_u = hi;
    end else begin
      clamp_u = val[31:0];
    end
  endfunction

endpackage

// File: rtl/lif_neuron.sv
// -----------------------------------------------------------------------------
// lif_neuron
// This is a single leaky integrate-and-fire neuron. On each enabled cycle it
// forms v - (v >> LEAK_SHIFT) + cur and saturates the result to 2^W-1.
// Reaching THRESH resets the membrane to zero and raises spike for one cycle.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   en          1 advances the neuron, 0 holds it
//   cur [W]     input current
//   spike       registered one-cycle spike pulse
//   state [W]   registered membrane potential
// -----------------------------------------------------------------------------
module lif_neuron
  import stdp_pkg::*;
#(
  parameter int W          = W_DEF,
  parameter int LEAK_SHIFT = LEAK_SHIFT_DEF,
  parameter int THRESH     = THRESH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] cur,
  output logic         spike,
  output logic [W-1:0] state
);

  localparam logic [31:0] VMAX = (32'd1 << W) - 32'd1;

  logic [W-1:0] v_r;
  logic         spike_r;
  logic [W:0]   sum_s;
  logic [W-1:0] sum_sat_s;
  logic         fire_s;

  // Leak, integrate and saturate; the W+1-bit sum cannot wrap.
  always_comb begin
    sum_s     = {1'b0, v_r} - {1'b0, (v_r >> LEAK_SHIFT)} + {1'b0, cur};
    sum_sat_s = W'(clamp_u(34'(sum_s), VMAX));
    fire_s    = (32'(sum_sat_s) >= 32'(THRESH));
  end

  // Membrane and spike registers; a crossing reloads zero and pulses once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_r     <= {W{1'b0}};
      spike_r <= 1'b0;
    end else if (en) begin
      if (fire_s) begin
        v_r     <= {W{1'b0}};
        spike_r <= 1'b1;
      end else begin
        v_r     <= sum_sat_s;
        spike_r <= 1'b0;
      end
    end
  end

  assign spike = spike_r;
  assign state = v_r;

endmodule

// File: rtl/lif_stdp_pair.sv
// -----------------------------------------------------------------------------
// lif_stdp_pair
// A presynaptic and a postsynaptic LIF neuron are joined by one plastic
// synapse. The pair uses pair-based STDP with linearly decaying trace timers.
// A post spike potentiates the weight in proportion to the presynaptic timer.
// A pre spike depresses it in proportion to the postsynaptic timer.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   en                    1 advances neurons/timers/weight, 0 holds everything
//   learn_en              1 permits weight changes (timers run regardless)
//   cur_pre [W]           current into the presynaptic neuron
//   cur_post [W]          external current into the postsynaptic neuron
//   spike_pre/spike_post  registered spike pulses
//   state_pre/state_post  registered membrane potentials
//   weight [WW]           current synaptic weight
// -----------------------------------------------------------------------------
module lif_stdp_pair
  import stdp_pkg::*;
#(
  parameter int W          = W_DEF,
  parameter int WW         = WW_DEF,
  parameter int TW         = TW_DEF,
  parameter int LEAK_SHIFT = LEAK_SHIFT_DEF,
  parameter int THRESH     = THRESH_DEF,
  parameter int W_INIT     = W_INIT_DEF,
  parameter int W_MAX      = W_MAX_DEF,
  parameter int A_PLUS     = A_PLUS_DEF,
  parameter int A_MINUS    = A_MINUS_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          learn_en,
  input  logic [W-1:0]  cur_pre,
  input  logic [W-1:0]  cur_post,
  output logic          spike_pre,
  output logic          spike_post,
  output logic [W-1:0]  state_pre,
  output logic [W-1:0]  state_post,
  output logic [WW-1:0] weight
);

  if (WW > W) begin : g_ww_check
    $error("lif_stdp_pair: WW must not exceed W");
  end

  localparam logic [TW-1:0] TMAX = {TW{1'b1}};
  localparam logic [31:0]   VMAX = (32'd1 << W) - 32'd1;

  logic [TW-1:0] pre_timer_r;
  logic [TW-1:0] post_timer_r;
  logic [WW-1:0] weight_r;
  logic [W-1:0]  syn_s;
  logic [W-1:0]  cur_post_s;
  logic [31:0]   ltp_s;
  logic [31:0]   ltd_s;
  logic [WW-1:0] weight_next_s;
  logic [TW-1:0] pre_timer_next_s;
  logic [TW-1:0] post_timer_next_s;

  lif_neuron #(.W(W), .LEAK_SHIFT(LEAK_SHIFT), .THRESH(THRESH)) u_pre (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .cur   (cur_pre),
    .spike (spike_pre),
    .state (state_pre)
  );

  lif_neuron #(.W(W), .LEAK_SHIFT(LEAK_SHIFT), .THRESH(THRESH)) u_post (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .cur   (cur_post_s),
    .spike (spike_post),
    .state (state_post)
  );

  // Synaptic drive into the post neuron and the STDP weight/timer next-state.
  always_comb begin
    if (spike_pre) begin
      syn_s = W'(weight_r);
    end else begin
      syn_s = {W{1'b0}};
    end
    cur_post_s = W'(clamp_u(34'(cur_post) + 34'(syn_s), VMAX));

    // Gains read the timers before this edge's reload/decrement.
    if (spike_post && learn_en) begin
      ltp_s = (32'(pre_timer_r) * 32'(A_PLUS)) >> TW;
    end else begin
      ltp_s = 32'd0;
    end
    if (spike_pre && learn_en) begin
      ltd_s = (32'(post_timer_r) * 32'(A_MINUS)) >> TW;
    end else begin
      ltd_s = 32'd0;
    end
    weight_next_s = WW'(clamp_u($signed(34'(weight_r)) + $signed(34'(ltp_s))
                                - $signed(34'(ltd_s)), 32'(W_MAX)));

    if (spike_pre) begin
      pre_timer_next_s = TMAX;
    end else if (pre_timer_r != {TW{1'b0}}) begin
      pre_timer_next_s = pre_timer_r - {{(TW-1){1'b0}}, 1'b1};
    end else begin
      pre_timer_next_s = {TW{1'b0}};
    end
    if (spike_post) begin
      post_timer_next_s = TMAX;
    end else if (post_timer_r != {TW{1'b0}}) begin
      post_timer_next_s = post_timer_r - {{(TW-1){1'b0}}, 1'b1};
    end else begin
      post_timer_next_s = {TW{1'b0}};
    end
  end

  // Trace timers and weight register; en=0 freezes all of them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_timer_r  <= {TW{1'b0}};
      post_timer_r <= {TW{1'b0}};
      weight_r     <= WW'(W_INIT);
    end else if (en) begin
      pre_timer_r  <= pre_timer_next_s;
      post_timer_r <= post_timer_next_s;
      weight_r     <= weight_next_s;
    end
  end

  assign weight = weight_r;

endmodule

// File: doc/lif_stdp_pair.md
LIF_STDP_PAIR -- requirements
Module: lif_stdp_pair

Interface
REQ-001 Parameter W, default 8: membrane state and input current width.
REQ-002 Parameter WW, default 8: synaptic weight width; WW <= W SHALL hold (elaboration error otherwise).
REQ-003 Parameter TW, default 4: STDP trace timer width; TMAX = 2^TW-1.
REQ-004 Parameter LEAK_SHIFT, default 3: leak is v >> LEAK_SHIFT per cycle.
REQ-005 Parameter THRESH, default 200: firing threshold.
REQ-006 Parameters W_INIT 64, W_MAX 255, A_PLUS 16, A_MINUS 16: initial weight, weight ceiling, LTP and LTD gains.
REQ-007 clk  in  1  single clock; all state changes on its rising edge.
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 en  in  1  advance neurons/timers/weight; 0 holds every register.
REQ-010 learn_en  in  1  1 permits weight updates; 0 freezes weight (timers still run).
REQ-011 cur_pre  in  W  input current to presynaptic neuron.
REQ-012 cur_post  in  W  external input current to postsynaptic neuron.
REQ-013 spike_pre, spike_post  out  1 each  registered one-cycle spike pulses.
REQ-014 state_pre, state_post  out  W each  registered membrane potentials.
REQ-015 weight  out  WW  current synaptic weight.

Function
REQ-016 Each neuron, when en=1, SHALL form sum = v - (v >> LEAK_SHIFT) + I in W+1 bits, saturated to 2^W-1.
REQ-017 If sum >= THRESH the neuron SHALL load v=0 and spike=1 next cycle; otherwise v=sum, spike=0 (latency one cycle; spike high exactly one cycle per crossing).
REQ-018 Presynaptic I = cur_pre; postsynaptic I = cur_post + (spike_pre ? weight : 0) zero-extended, saturated to 2^W-1.
REQ-019 pre_timer SHALL load TMAX on the cycle after spike_pre=1, else decrement by 1 per en cycle, saturating at 0; post_timer identically from spike_post.
REQ-020 In a cycle with spike_post=1 and learn_en=1, ltp = (pre_timer * A_PLUS) >> TW, using pre-update timer value; else ltp=0.
REQ-021 In a cycle with spike_pre=1 and learn_en=1, ltd = (post_timer * A_MINUS) >> TW, using pre-update timer value; else ltd=0.
REQ-022 Next weight = clamp(weight + ltp - ltd, 0, W_MAX), computed signed with sufficient width (no wrap); visible one cycle later.
REQ-023 Simultaneous spike_pre and spike_post: both ltp and ltd applied in the same update; both timers reload.
REQ-024 Timer at 0 yields zero change (no learning outside the TMAX window).

Reset
REQ-025 rst_n low SHALL immediately force state_pre=state_post=0, spike_pre=spike_post=0, both timers 0, weight=W_INIT, independent of clk.
REQ-026 Reset deassertion mid-run SHALL resume from these values on the next rising edge; no partial update survives.

Structure
REQ-027 Default constants and the clamp/saturate helper SHALL live in shared package stdp_pkg.
REQ-028 One sub-module lif_neuron (parameters W, LEAK_SHIFT, THRESH) SHALL be instantiated twice; timers and weight logic stay in lif_stdp_pair.

Verification
REQ-029 Reset: rst_n=0 mid-run -> all outputs 0, weight=64 without a clock edge.
REQ-030 Integration: cur_pre=64 constant, en=1 -> state_pre 64,120,169, then spike_pre=1 with state_pre=0 on cycle 4.
REQ-031 LTP: spike_pre at t, cur_post=255 pulse making spike_post at t+3 -> pre_timer=13, weight 64 -> 77 at t+4.
REQ-032 LTD: spike_post at t, spike_pre at t+2 -> post_timer=14, weight 64 -> 50.
REQ-033 Saturation: W_INIT=250 with ltp=15 -> weight 255; W_INIT=5 with ltd=14 -> weight 0.
REQ-034 Gating: learn_en=0 during REQ-031 stimulus -> weight stays 64; en=0 -> all registers hold; simultaneous spikes with both timers 0 -> weight unchanged.
